// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_ctrl_pkg
// Description : Shared widths, default thresholds and the controller state
//               type for the PLL gain scheduler slice.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_ctrl_pkg;

    localparam int GAIN_W = 3;     // loop gain width
    localparam int STEP_W = 8;     // oscillator frequency step width
    localparam int EDGE_W = 8;     // per-window edge counter width

    localparam int DEF_WIN_LOG2       = 8;
    localparam int DEF_FREQ_INIT      = 16;
    localparam int DEF_EDGE_TOL       = 1;
    localparam int DEF_ERR_LOCK_THR   = 32;
    localparam int DEF_ERR_UNLOCK_THR = 96;
    localparam int DEF_GAIN_FINAL     = 4;
    localparam int DEF_LOCK_COUNT     = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FSEARCH = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_gain_scheduler_edge_counter.sv
`default_nettype none
// ============================================================================
// Module      : pll_edge_counter
// Description : Optional 2-flop synchroniser, rising-edge detector and a
//               saturating per-window edge counter.
// Ports       : clk, rst_n   - clock, async active-low reset
//               clear        - hold counter at zero (controller idle)
//               terminal     - last cycle of the measurement window
//               sig          - monitored clock-like input
//               count        - edges seen so far in the current window
// Revision    : 1.0 - initial release
// ============================================================================
module pll_edge_counter #(
    parameter bit SYNC  = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             terminal,
    input  logic             sig,
    output logic [CNT_W-1:0] count
);

    logic sampled;
    logic prev;
    logic rise;

    generate
        if (SYNC) begin : g_sync
            logic meta;
            logic stable;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta   <= 1'b0;
                    stable <= 1'b0;
                end else begin
                    meta   <= sig;
                    stable <= meta;
                end
            end
            assign sampled = stable;
        end else begin : g_direct
            assign sampled = sig;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= sampled;
    end

    assign rise = sampled & ~prev;

    // On the terminal cycle the controller consumes the old count; the
    // terminal cycle's own edge seeds the next window so nothing is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (terminal) begin
            count <= {{(CNT_W-1){1'b0}}, rise};
        end else if (rise && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_gain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pll_gain_scheduler
// Description : Window-based PLL controller: coarse frequency search on
//               ref/rec edge counts, loop-gain ramp on phase-error duty and
//               lock detection with hysteresis.
// Ports       : i_sys_clk, i_rst_n     - clock, async active-low reset
//               i_en                   - enable automatic control
//               i_ref_clk              - async reference clock
//               i_rec_clk              - recovered clock (sys domain)
//               i_phase_error          - phase detector flag
//               i_manual, i_man_gain, i_man_step - manual override
//               o_loop_gain, o_freq_step, o_locked, o_state - outputs
// Revision    : 1.0 - initial release
// ============================================================================
module pll_gain_scheduler
    import pll_ctrl_pkg::*;
#(
    parameter int WIN_LOG2       = DEF_WIN_LOG2,
    parameter int FREQ_INIT      = DEF_FREQ_INIT,
    parameter int EDGE_TOL       = DEF_EDGE_TOL,
    parameter int ERR_LOCK_THR   = DEF_ERR_LOCK_THR,
    parameter int ERR_UNLOCK_THR = DEF_ERR_UNLOCK_THR,
    parameter int GAIN_FINAL     = DEF_GAIN_FINAL,
    parameter int LOCK_COUNT     = DEF_LOCK_COUNT
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_ref_clk,
    input  logic              i_rec_clk,
    input  logic              i_phase_error,
    input  logic              i_manual,
    input  logic [GAIN_W-1:0] i_man_gain,
    input  logic [STEP_W-1:0] i_man_step,
    output logic [GAIN_W-1:0] o_loop_gain,
    output logic [STEP_W-1:0] o_freq_step,
    output logic              o_locked,
    output logic [2:0]        o_state
);

    localparam int                ERR_W       = WIN_LOG2 + 1;
    localparam logic [9:0]        TOL         = 10'(EDGE_TOL);
    localparam logic [ERR_W-1:0]  LOCK_THR    = ERR_W'(ERR_LOCK_THR);
    localparam logic [ERR_W-1:0]  UNLOCK_THR  = ERR_W'(ERR_UNLOCK_THR);
    localparam logic [GAIN_W-1:0] GAIN_TOP    = GAIN_W'(GAIN_FINAL);
    localparam logic [STEP_W-1:0] STEP_INIT   = STEP_W'(FREQ_INIT);
    localparam logic [STEP_W-1:0] STEP_MIN    = STEP_W'(1);
    localparam logic [7:0]        GOOD_TARGET = 8'(LOCK_COUNT);

    state_t              state;
    logic [WIN_LOG2-1:0] win;
    logic [ERR_W-1:0]    err_cnt;
    logic [EDGE_W-1:0]   ref_edges;
    logic [EDGE_W-1:0]   rec_edges;
    logic [7:0]          good_cnt;
    logic [GAIN_W-1:0]   gain;
    logic [STEP_W-1:0]   step;
    logic                locked;

    logic idle;
    logic terminal;
    logic step_up;
    logic step_down;
    logic mismatch;

    assign idle     = (state == ST_IDLE);
    assign terminal = !idle && (&win);

    // Widened compares so the tolerance addition cannot wrap.
    assign step_up   = ({2'b00, rec_edges} + TOL) < {2'b00, ref_edges};
    assign step_down = {2'b00, rec_edges} > ({2'b00, ref_edges} + TOL);
    assign mismatch  = step_up | step_down;

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n)  win <= '0;
        else if (idle) win <= '0;
        else           win <= win + 1'b1;
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt <= '0;
        end else if (idle) begin
            err_cnt <= '0;
        end else if (terminal) begin
            err_cnt <= {{(ERR_W-1){1'b0}}, i_phase_error};
        end else if (i_phase_error && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    pll_edge_counter #(
        .SYNC  (1'b1),
        .CNT_W (EDGE_W)
    ) u_ref_cnt (
        .clk      (i_sys_clk),
        .rst_n    (i_rst_n),
        .clear    (idle),
        .terminal (terminal),
        .sig      (i_ref_clk),
        .count    (ref_edges)
    );

    pll_edge_counter #(
        .SYNC  (1'b0),
        .CNT_W (EDGE_W)
    ) u_rec_cnt (
        .clk      (i_sys_clk),
        .rst_n    (i_rst_n),
        .clear    (idle),
        .terminal (terminal),
        .sig      (i_rec_clk),
        .count    (rec_edges)
    );

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            gain     <= '0;
            step     <= STEP_INIT;
            locked   <= 1'b0;
            good_cnt <= '0;
        end else if (i_manual) begin
            state    <= ST_IDLE;
            locked   <= 1'b0;
            gain     <= i_man_gain;
            step     <= i_man_step;
        end else if (!i_en) begin
            state    <= ST_IDLE;
            locked   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_FSEARCH;
                    step  <= STEP_INIT;
                    gain  <= '0;
                end
                ST_FSEARCH: if (terminal) begin
                    if (step_up) begin
                        if (step != '1) step <= step + 1'b1;
                    end else if (step_down) begin
                        if (step > STEP_MIN) step <= step - 1'b1;
                    end else begin
                        state <= ST_ACQUIRE;
                        gain  <= '0;
                    end
                end
                ST_ACQUIRE: if (terminal) begin
                    if (mismatch) begin
                        state <= ST_FSEARCH;
                    end else if (err_cnt <= LOCK_THR) begin
                        if (gain < GAIN_TOP) begin
                            gain <= gain + 1'b1;
                        end else begin
                            state    <= ST_VERIFY;
                            good_cnt <= 8'd1;
                        end
                    end
                end
                ST_VERIFY: if (terminal) begin
                    if (mismatch) begin
                        state <= ST_FSEARCH;
                    end else if (err_cnt > LOCK_THR) begin
                        state <= ST_ACQUIRE;
                        gain  <= '0;
                    end else begin
                        good_cnt <= good_cnt + 8'd1;
                        if ((good_cnt + 8'd1) >= GOOD_TARGET) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: if (terminal) begin
                    // Errors between the lock and unlock thresholds keep lock.
                    if (mismatch) begin
                        state  <= ST_FSEARCH;
                        locked <= 1'b0;
                        gain   <= '0;
                    end else if (err_cnt > UNLOCK_THR) begin
                        state  <= ST_ACQUIRE;
                        locked <= 1'b0;
                        gain   <= '0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign o_loop_gain = gain;
    assign o_freq_step = step;
    assign o_locked    = locked;
    assign o_state     = state;

endmodule
`default_nettype wire

// File: tb/tb_pll_gain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_gain_scheduler
// Description : Self-checking bench for pll_gain_scheduler with a window-level
//               behavioural model and directed plus randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pll_gain_scheduler;

    localparam int WIN        = 256;
    localparam int FREQ_INIT  = 16;
    localparam int TOL        = 1;
    localparam int LOCK_THR   = 32;
    localparam int UNLOCK_THR = 96;
    localparam int GAIN_FINAL = 4;
    localparam int LOCK_COUNT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       ref_clk = 1'b0;
    logic       rec_clk = 1'b0;
    logic       pe = 1'b0;
    logic       manual = 1'b0;
    logic [2:0] man_gain = 3'd0;
    logic [7:0] man_step = 8'd0;
    logic [2:0] loop_gain;
    logic [7:0] freq_step;
    logic       locked;
    logic [2:0] state;

    logic       en_hi = 1'b0;
    logic       ref_hi = 1'b0;
    logic [2:0] gain_hi;
    logic [7:0] step_hi;
    logic       locked_hi;
    logic [2:0] state_hi;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    pll_gain_scheduler dut (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_ref_clk(ref_clk),
        .i_rec_clk(rec_clk), .i_phase_error(pe), .i_manual(manual),
        .i_man_gain(man_gain), .i_man_step(man_step),
        .o_loop_gain(loop_gain), .o_freq_step(freq_step),
        .o_locked(locked), .o_state(state)
    );

    // Second instance starting near the top of the step range to reach the
    // upper saturation point quickly.
    pll_gain_scheduler #(.FREQ_INIT(250)) dut_hi (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_en(en_hi), .i_ref_clk(ref_hi),
        .i_rec_clk(1'b0), .i_phase_error(1'b0), .i_manual(1'b0),
        .i_man_gain(3'd0), .i_man_step(8'd0),
        .o_loop_gain(gain_hi), .o_freq_step(step_hi),
        .o_locked(locked_hi), .o_state(state_hi)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stimulus generator ----------------
    int         cyc = 0;
    int         ref_per = 32;
    int         ref_ofs = 0;
    int         rec_mode = 0;   // 0: NCO from freq_step, 1: period 4, 2: absent
    int         pe_mode = 0;    // 0: none, 1: 60/window, 2: 128/window, 3: random
    int         pe_duty = 0;
    logic [7:0] acc = 8'd0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            acc = acc + freq_step;
            case (rec_mode)
                0:       rec_clk = acc[7];
                1:       rec_clk = (cyc % 4) < 2;
                default: rec_clk = 1'b0;
            endcase
            ref_clk = (ref_per == 0) ? 1'b0 : (((cyc + ref_ofs) % ref_per) < (ref_per / 2));
            case (pe_mode)
                1:       pe = (cyc % 64) < 15;
                2:       pe = (cyc % 2) == 1;
                3:       pe = $urandom_range(0, 255) < pe_duty;
                default: pe = 1'b0;
            endcase
            ref_hi = (cyc % 4) < 2;
        end
    end

    // ---------------- behavioural model ----------------
    // Tracks window position and per-window totals as plain integers and
    // applies the controller rules once per completed window.
    int m_state, m_gain, m_step, m_locked, m_good, m_pos, m_ref, m_rec, m_err;
    bit h_ref1, h_ref2, h_ref3, h_rec1;

    always @(posedge clk or negedge rst_n) begin
        int ev_ref, ev_rec, ev_pe, st, w_ref, w_rec, w_err;
        bit term, fast, slow;
        if (!rst_n) begin
            m_state = 0; m_gain = 0; m_step = FREQ_INIT; m_locked = 0; m_good = 0;
            m_pos = 0; m_ref = 0; m_rec = 0; m_err = 0;
            h_ref1 = 0; h_ref2 = 0; h_ref3 = 0; h_rec1 = 0;
        end else begin
            // ref reaches the edge detector two samples late (synchroniser)
            ev_ref = (h_ref2 && !h_ref3) ? 1 : 0;
            ev_rec = (rec_clk && !h_rec1) ? 1 : 0;
            ev_pe  = pe ? 1 : 0;
            h_ref3 = h_ref2; h_ref2 = h_ref1; h_ref1 = ref_clk; h_rec1 = rec_clk;
            st = m_state; w_ref = m_ref; w_rec = m_rec; w_err = m_err;
            term = (st != 0) && (m_pos == WIN - 1);
            if (st == 0) begin
                m_pos = 0; m_ref = 0; m_rec = 0; m_err = 0;
            end else begin
                m_pos = (m_pos + 1) % WIN;
                if (term) begin
                    m_ref = ev_ref; m_rec = ev_rec; m_err = ev_pe;
                end else begin
                    m_ref = (m_ref + ev_ref > 255) ? 255 : m_ref + ev_ref;
                    m_rec = (m_rec + ev_rec > 255) ? 255 : m_rec + ev_rec;
                    m_err = (m_err + ev_pe > 2*WIN-1) ? 2*WIN-1 : m_err + ev_pe;
                end
            end
            fast = w_ref > w_rec + TOL;
            slow = w_rec > w_ref + TOL;
            if (manual) begin
                m_state = 0; m_locked = 0; m_gain = int'(man_gain); m_step = int'(man_step);
            end else if (!en) begin
                m_state = 0; m_locked = 0;
            end else if (st == 0) begin
                m_state = 1; m_step = FREQ_INIT; m_gain = 0;
            end else if (term) begin
                case (st)
                    1: if (fast) m_step = (m_step >= 255) ? 255 : m_step + 1;
                       else if (slow) m_step = (m_step <= 1) ? 1 : m_step - 1;
                       else begin m_state = 2; m_gain = 0; end
                    2: if (fast || slow) m_state = 1;
                       else if (w_err <= LOCK_THR) begin
                           if (m_gain < GAIN_FINAL) m_gain = m_gain + 1;
                           else begin m_state = 3; m_good = 1; end
                       end
                    3: if (fast || slow) m_state = 1;
                       else if (w_err > LOCK_THR) begin m_state = 2; m_gain = 0; end
                       else begin
                           m_good = m_good + 1;
                           if (m_good >= LOCK_COUNT) begin m_state = 4; m_locked = 1; end
                       end
                    4: if (fast || slow) begin m_state = 1; m_locked = 0; m_gain = 0; end
                       else if (w_err > UNLOCK_THR) begin m_state = 2; m_locked = 0; m_gain = 0; end
                    default: m_state = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("model_gain",   32'(loop_gain), 32'(m_gain));
                check("model_step",   32'(freq_step), 32'(m_step));
                check("model_locked", 32'(locked),    32'(m_locked));
                check("model_state",  32'(state),     32'(m_state));
            end
        end
    end

    task automatic wait_state(input logic [2:0] want, input int max_cyc, input string nm);
        int n = 0;
        while (state !== want && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(state), 32'(want));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random sequence ----------------
    initial begin
        ref_ofs = $urandom_range(0, 31);
        #1 rst_n = 1'b0;
        model_on = 1'b1;
        #1;
        check("rst_gain",   32'(loop_gain), 0);
        check("rst_step",   32'(freq_step), 16);
        check("rst_locked", 32'(locked),    0);
        check("rst_state",  32'(state),     0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_hold_state", 32'(state), 0);

        // frequency search then gain ramp to lock
        en = 1'b1; en_hi = 1'b1;
        wait_state(3'd2, 14*WIN, "search_reach_acquire");
        check("search_step_band", 32'((freq_step == 8'd8) || (freq_step == 8'd9)), 1);
        wait_state(3'd4, 12*WIN, "ramp_reach_locked");
        check("lock_flag", 32'(locked),    1);
        check("lock_gain", 32'(loop_gain), 4);

        // hysteresis band: 60 errors per window keeps lock
        pe_mode = 1;
        repeat (3*WIN) @(negedge clk);
        check("hyst_locked", 32'(locked), 1);
        check("hyst_state",  32'(state),  4);

        // heavy phase error breaks lock
        pe_mode = 2;
        wait_state(3'd2, 3*WIN, "unlock_to_acquire");
        check("unlock_flag", 32'(locked),    0);
        check("unlock_gain", 32'(loop_gain), 0);
        pe_mode = 0;
        wait_state(3'd4, 12*WIN, "relock");

        check("hi_step_sat",  32'(step_hi),  255);
        check("hi_state",     32'(state_hi), 1);

        // asynchronous reset in the middle of a cycle while locked
        @(negedge clk);
        check("pre_reset_locked", 32'(locked), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_gain",   32'(loop_gain), 0);
        check("async_step",   32'(freq_step), 16);
        check("async_locked", 32'(locked),    0);
        check("async_state",  32'(state),     0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // manual override and release
        manual = 1'b1; man_gain = 3'd6; man_step = 8'd200;
        @(negedge clk);
        check("man_gain",  32'(loop_gain), 6);
        check("man_step",  32'(freq_step), 200);
        check("man_state", 32'(state),     0);
        repeat (3) @(negedge clk);
        manual = 1'b0;
        @(negedge clk);
        check("release_state", 32'(state),     1);
        check("release_step",  32'(freq_step), 16);
        check("release_gain",  32'(loop_gain), 0);

        // lower saturation: no reference, fast recovered clock
        ref_per = 0; rec_mode = 1;
        repeat (18*WIN) @(negedge clk);
        check("low_sat_step",  32'(freq_step), 1);
        check("low_sat_state", 32'(state),     1);

        // randomized windows against the model
        rec_mode = 0; pe_mode = 3;
        for (int w = 0; w < 12; w++) begin
            ref_per = $urandom_range(20, 48);
            pe_duty = $urandom_range(0, 120);
            if ($urandom_range(0, 3) == 0) begin
                manual = 1'b1;
                man_gain = 3'($urandom_range(0, 7));
                man_step = 8'($urandom_range(0, 255));
                repeat ($urandom_range(1, 5)) @(negedge clk);
                manual = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                en = 1'b1;
            end
            repeat (WIN) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
